// File: rtl/clk_rst_seq_pkg.sv
// Shared types for the clock/reset sequencer: FSM state encoding,
// state width and a small sizing helper.
package clk_rst_seq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_PERIPH    = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/clk_rst_sync.sv
// Multi-flop synchronizer for the clock wizard lock signal.
// Ports: clk_i, rst_i (sync, active-high), d_i (async in), q_o (synced out).
module clk_rst_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Clock wizard reset/lock sequencer: holds the PLL in reset, waits for a
// stable lock, then releases peripheral reset followed by core reset.
// Ports: clk_in1, reset (sync, active-high), locked_in (async),
//   soft_rst_req (pulse) -> pll_resetn, periph_rst, core_rst, ready,
//   lock_fail, state_o[2:0], lock_loss_cnt[7:0].
// Option: define CLK_RST_SEQ_LOCK_LOSS_CNT_EN to build the lock-loss
//   counter; otherwise lock_loss_cnt reads 0.
module clk_rst_sequencer
  import clk_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int CORE_DELAY     = 16,
  parameter int MAX_RETRIES    = 3,
  parameter int SYNC_STAGES    = 2
) (
  input  logic               clk_in1,
  input  logic               reset,
  input  logic               locked_in,
  input  logic               soft_rst_req,
  output logic               pll_resetn,
  output logic               periph_rst,
  output logic               core_rst,
  output logic               ready,
  output logic               lock_fail,
  output logic [STATE_W-1:0] state_o,
  output logic [7:0]         lock_loss_cnt
);

  localparam int MAXC = max_of(max_of(PLL_RST_CYCLES, LOCK_TIMEOUT),
                               max_of(STABLE_CYCLES, CORE_DELAY));
  localparam int CNT_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int RT_W  = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [CNT_W-1:0] PLL_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STB_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CORE_LAST = CNT_W'(CORE_DELAY - 1);
  localparam logic [RT_W-1:0]  RT_MAX    = RT_W'(MAX_RETRIES);

  logic             locked_s;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RT_W-1:0]  retry_q, retry_d;
  logic             pll_resetn_q, periph_rst_q, core_rst_q;
  logic             ready_q, lock_fail_q;

  clk_rst_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (clk_in1),
    .rst_i (reset),
    .d_i   (locked_in),
    .q_o   (locked_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    retry_d = retry_q;
    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PLL_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_WAIT_LOCK: begin
        if (locked_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          cnt_d   = '0;
          retry_d = retry_q + 1'b1;
          if (retry_d == RT_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_PLL_RST;
          end
        end
      end
      ST_STABILIZE: begin
        // Lock drop wins over completion: a glitch on the last count
        // must not release the resets.
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_PERIPH;
          cnt_d   = '0;
        end
      end
      ST_PERIPH: begin
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CORE_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase
    if (soft_rst_req) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = '0;
    end
  end

  // Outputs decode the next state so they change on the same edge
  // as the state register.
  always_ff @(posedge clk_in1) begin
    if (reset) begin
      state_q      <= ST_PLL_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      pll_resetn_q <= 1'b0;
      periph_rst_q <= 1'b1;
      core_rst_q   <= 1'b1;
      ready_q      <= 1'b0;
      lock_fail_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      pll_resetn_q <= !(state_d == ST_PLL_RST || state_d == ST_FAIL);
      periph_rst_q <= !(state_d == ST_PERIPH || state_d == ST_RUN);
      core_rst_q   <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      lock_fail_q  <= (state_d == ST_FAIL);
    end
  end

  assign pll_resetn = pll_resetn_q;
  assign periph_rst = periph_rst_q;
  assign core_rst   = core_rst_q;
  assign ready      = ready_q;
  assign lock_fail  = lock_fail_q;
  assign state_o    = state_q;

`ifdef CLK_RST_SEQ_LOCK_LOSS_CNT_EN
  logic [7:0] llc_q;

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      llc_q <= '0;
    end else if (state_q == ST_RUN && state_d == ST_WAIT_LOCK
                 && llc_q != 8'hFF) begin
      llc_q <= llc_q + 8'd1;
    end
  end

  assign lock_loss_cnt = llc_q;
`else
  assign lock_loss_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Directed bench for clk_rst_sequencer with small timing parameters.
// Expected outputs are hand-computed per step.
module tb_clk_rst_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       locked_in;
  logic       soft_rst_req;
  logic       pll_resetn;
  logic       periph_rst;
  logic       core_rst;
  logic       ready;
  logic       lock_fail;
  logic [2:0] state_o;
  logic [7:0] lock_loss_cnt;

  int vectors = 0;
  int errors  = 0;

  localparam logic [2:0] PR = 3'd0;
  localparam logic [2:0] WL = 3'd1;
  localparam logic [2:0] SB = 3'd2;
  localparam logic [2:0] PH = 3'd3;
  localparam logic [2:0] RN = 3'd4;
  localparam logic [2:0] FL = 3'd5;

`ifdef CLK_RST_SEQ_LOCK_LOSS_CNT_EN
  localparam int LLC_ON = 1;
`else
  localparam int LLC_ON = 0;
`endif

  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .CORE_DELAY     (4),
    .MAX_RETRIES    (2),
    .SYNC_STAGES    (2)
  ) dut (
    .clk_in1       (clk),
    .reset         (reset),
    .locked_in     (locked_in),
    .soft_rst_req  (soft_rst_req),
    .pll_resetn    (pll_resetn),
    .periph_rst    (periph_rst),
    .core_rst      (core_rst),
    .ready         (ready),
    .lock_fail     (lock_fail),
    .state_o       (state_o),
    .lock_loss_cnt (lock_loss_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Packs {state, pll_resetn, periph_rst, core_rst, ready, lock_fail}.
  task automatic chk_st(input string tag, input logic [2:0] st,
                        input logic pll, input logic per,
                        input logic core, input logic rdy,
                        input logic fl);
    chk(tag, {state_o, pll_resetn, periph_rst, core_rst, ready, lock_fail},
        {st, pll, per, core, rdy, fl});
  endtask

  initial begin
    reset        = 1'b1;
    locked_in    = 1'b0;
    soft_rst_req = 1'b0;
    tick(3);
    chk_st("reset_state", PR, 0, 1, 1, 0, 0);
    chk("reset_llc", lock_loss_cnt, 8'd0);

    // T1 nominal bring-up
    reset = 1'b0;
    tick(3);
    chk_st("t1_pllrst_held", PR, 0, 1, 1, 0, 0);
    tick(1);
    chk_st("t1_wait_lock", WL, 1, 1, 1, 0, 0);
    tick(10);
    locked_in = 1'b1;
    tick(2);
    chk_st("t1_sync_lag", WL, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t1_stabilize", SB, 1, 1, 1, 0, 0);
    tick(7);
    chk_st("t1_stab_end", SB, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t1_periph", PH, 1, 0, 1, 0, 0);
    tick(3);
    chk_st("t1_periph_end", PH, 1, 0, 1, 0, 0);
    tick(1);
    chk_st("t1_run", RN, 1, 0, 0, 1, 0);

    // T4 lock loss in RUN
    locked_in = 1'b0;
    tick(2);
    chk_st("t4_still_run", RN, 1, 0, 0, 1, 0);
    tick(1);
    chk_st("t4_lost", WL, 1, 1, 1, 0, 0);
    chk("t4_llc", lock_loss_cnt, 8'(LLC_ON));

    // T2 one-cycle glitch at stabilize count 5
    locked_in = 1'b1;
    tick(3);
    chk_st("t2_stabilize", SB, 1, 1, 1, 0, 0);
    tick(5);
    locked_in = 1'b0;
    tick(1);
    locked_in = 1'b1;
    tick(1);
    chk_st("t2_glitch_pending", SB, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t2_back_wait", WL, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t2_restab", SB, 1, 1, 1, 0, 0);
    tick(7);
    chk_st("t2_stab_full", SB, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t2_periph", PH, 1, 0, 1, 0, 0);
    tick(4);
    chk_st("t2_run", RN, 1, 0, 0, 1, 0);

    // T5 soft reset coincides with stabilize completion
    locked_in = 1'b0;
    tick(3);
    chk_st("t5_lost", WL, 1, 1, 1, 0, 0);
    chk("t5_llc", lock_loss_cnt, 8'(2 * LLC_ON));
    locked_in = 1'b1;
    tick(3);
    chk_st("t5_stabilize", SB, 1, 1, 1, 0, 0);
    tick(7);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    chk_st("t5_soft_wins", PR, 0, 1, 1, 0, 0);
    tick(3);
    chk_st("t5_pllrst", PR, 0, 1, 1, 0, 0);
    tick(1);
    chk_st("t5_wait", WL, 1, 1, 1, 0, 0);

    // T6 reset while in PERIPH
    tick(1);
    chk_st("t6_stabilize", SB, 1, 1, 1, 0, 0);
    tick(8);
    chk_st("t6_periph", PH, 1, 0, 1, 0, 0);
    reset     = 1'b1;
    locked_in = 1'b0;
    tick(1);
    chk_st("t6_reset", PR, 0, 1, 1, 0, 0);
    chk("t6_llc", lock_loss_cnt, 8'd0);
    reset = 1'b0;

    // T3 no lock: two timeouts then FAIL
    tick(3);
    chk_st("t3_pllrst1", PR, 0, 1, 1, 0, 0);
    tick(1);
    chk_st("t3_wait1", WL, 1, 1, 1, 0, 0);
    tick(31);
    chk_st("t3_wait1_end", WL, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t3_retry_pllrst", PR, 0, 1, 1, 0, 0);
    tick(3);
    chk_st("t3_pllrst2", PR, 0, 1, 1, 0, 0);
    tick(1);
    chk_st("t3_wait2", WL, 1, 1, 1, 0, 0);
    tick(31);
    chk_st("t3_wait2_end", WL, 1, 1, 1, 0, 0);
    tick(1);
    chk_st("t3_fail", FL, 0, 1, 1, 0, 1);
    tick(5);
    chk_st("t3_fail_hold", FL, 0, 1, 1, 0, 1);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    chk_st("t3_soft_exit", PR, 0, 1, 1, 0, 0);

    // Soft request inside PLL_RST restarts its count
    tick(2);
    soft_rst_req = 1'b1;
    tick(1);
    soft_rst_req = 1'b0;
    tick(3);
    chk_st("soft_restart_hold", PR, 0, 1, 1, 0, 0);
    tick(1);
    chk_st("soft_restart_wait", WL, 1, 1, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
